// File: rtl/xor_stream_if.sv
// ============================================================================
//  Module      : xor_stream_if
//  Description : Pin-side bundle of the XOR stream engine: serial load inputs,
//                serial ciphertext output and status flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface xor_stream_if;
    logic ena;
    logic iData_in;
    logic iKey_flag;
    logic iMsg_flag;
    logic iMode;
    logic oData_out;
    logic oData_flag;
    logic oBusy;
    logic oKey_valid;
    logic oError;

    modport master (
        output ena,
        output iData_in,
        output iKey_flag,
        output iMsg_flag,
        output iMode,
        input  oData_out,
        input  oData_flag,
        input  oBusy,
        input  oKey_valid,
        input  oError
    );

    modport slave (
        input  ena,
        input  iData_in,
        input  iKey_flag,
        input  iMsg_flag,
        input  iMode,
        output oData_out,
        output oData_flag,
        output oBusy,
        output oKey_valid,
        output oError
    );
endinterface

`default_nettype wire

// File: rtl/xor_stream_engine.sv
// ============================================================================
//  Module      : xor_stream_engine
//  Description : Serial key/message loader, chunked static or rolling XOR
//                encryption, and MSB-first serial ciphertext output.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module xor_stream_engine #(
    parameter int MSG_SIZE = 64,
    parameter int KEY_SIZE = 8
) (
    input  logic        clk,
    input  logic        rst,
    xor_stream_if.slave bus
);

    localparam int N_CHUNKS = MSG_SIZE / KEY_SIZE;
    localparam int KCNT_W   = $clog2(KEY_SIZE) + 1;
    localparam int MCNT_W   = $clog2(MSG_SIZE) + 1;
    localparam int CCNT_W   = $clog2(N_CHUNKS) + 1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ENCRYPT = 2'd1;
    localparam logic [1:0] c_SHIFT   = 2'd2;

    localparam logic [KCNT_W-1:0] c_KEY_FULL   = KCNT_W'(KEY_SIZE);
    localparam logic [KCNT_W-1:0] c_KCNT_ONE   = KCNT_W'(1);
    localparam logic [MCNT_W-1:0] c_MSG_FULL   = MCNT_W'(MSG_SIZE);
    localparam logic [MCNT_W-1:0] c_MCNT_ONE   = MCNT_W'(1);
    localparam logic [MCNT_W-1:0] c_BIT_LAST   = MCNT_W'(MSG_SIZE - 1);
    localparam logic [CCNT_W-1:0] c_CHUNK_LAST = CCNT_W'(N_CHUNKS - 1);
    localparam logic [CCNT_W-1:0] c_CCNT_ONE   = CCNT_W'(1);

    logic [1:0]          state_q,     state_d;
    logic [KEY_SIZE-1:0] key_q,       key_d;
    logic [KEY_SIZE-1:0] wkey_q,      wkey_d;
    logic [KCNT_W-1:0]   key_cnt_q,   key_cnt_d;
    logic                key_valid_q, key_valid_d;
    logic                key_prev_q,  key_prev_d;
    logic [MSG_SIZE-1:0] msg_q,       msg_d;
    logic [MCNT_W-1:0]   msg_cnt_q,   msg_cnt_d;
    logic                msg_prev_q,  msg_prev_d;
    logic                mode_q,      mode_d;
    logic [MSG_SIZE-1:0] ct_q,        ct_d;
    logic [CCNT_W-1:0]   chunk_q,     chunk_d;
    logic [MCNT_W-1:0]   bit_q,       bit_d;
    logic                data_out_q,  data_out_d;
    logic                data_flag_q, data_flag_d;
    logic                error_q,     error_d;

    logic                w_key_first;
    logic                w_key_take;
    logic [KCNT_W-1:0]   w_key_next;
    logic [KEY_SIZE-1:0] w_key_shift;
    logic                w_msg_first;
    logic                w_msg_take;
    logic [MCNT_W-1:0]   w_msg_next;
    logic [MSG_SIZE-1:0] w_msg_shift;
    logic                w_flag_rise;
    logic [KEY_SIZE-1:0] w_wkey_rot;
    logic [MSG_SIZE-1:0] w_ct_next;

    // A burst restarts on the first flagged cycle after the flag was low;
    // once the counter is full, further bits of the same burst are dropped.
    assign w_key_first = ~key_prev_q;
    assign w_key_take  = w_key_first | (key_cnt_q < c_KEY_FULL);
    assign w_key_next  = (w_key_first ? '0 : key_cnt_q) + c_KCNT_ONE;
    assign w_key_shift = (key_q << 1) | KEY_SIZE'(bus.iData_in);

    assign w_msg_first = ~msg_prev_q;
    assign w_msg_take  = w_msg_first | (msg_cnt_q < c_MSG_FULL);
    assign w_msg_next  = (w_msg_first ? '0 : msg_cnt_q) + c_MCNT_ONE;
    assign w_msg_shift = (msg_q << 1) | MSG_SIZE'(bus.iData_in);

    assign w_flag_rise = (bus.iKey_flag & ~key_prev_q) | (bus.iMsg_flag & ~msg_prev_q);

    // The message register is consumed from the top, so the ciphertext fills
    // from the bottom and ends with chunk 0 in the most significant position.
    assign w_ct_next = (ct_q << KEY_SIZE)
                     | MSG_SIZE'(msg_q[MSG_SIZE-1 -: KEY_SIZE] ^ wkey_q);

    generate
        if (KEY_SIZE > 1) begin : g_rot_multi
            assign w_wkey_rot = {wkey_q[KEY_SIZE-2:0], wkey_q[KEY_SIZE-1]};
        end else begin : g_rot_single
            assign w_wkey_rot = wkey_q;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        key_d       = key_q;
        wkey_d      = wkey_q;
        key_cnt_d   = key_cnt_q;
        key_valid_d = key_valid_q;
        key_prev_d  = key_prev_q;
        msg_d       = msg_q;
        msg_cnt_d   = msg_cnt_q;
        msg_prev_d  = msg_prev_q;
        mode_d      = mode_q;
        ct_d        = ct_q;
        chunk_d     = chunk_q;
        bit_d       = bit_q;
        data_out_d  = data_out_q;
        data_flag_d = data_flag_q;
        error_d     = error_q;

        if (bus.ena) begin
            key_prev_d = bus.iKey_flag;
            msg_prev_d = bus.iMsg_flag;
            error_d    = 1'b0;

            case (state_q)
                c_IDLE: begin
                    data_out_d  = 1'b0;
                    data_flag_d = 1'b0;
                    if (bus.iKey_flag && bus.iMsg_flag) begin
                        error_d = 1'b1;
                    end else if (bus.iKey_flag) begin
                        if (w_key_take) begin
                            key_d       = w_key_shift;
                            key_cnt_d   = w_key_next;
                            key_valid_d = (w_key_next == c_KEY_FULL);
                        end
                    end else if (bus.iMsg_flag && w_msg_take) begin
                        msg_d     = w_msg_shift;
                        msg_cnt_d = w_msg_next;
                        if (w_msg_next == c_MSG_FULL) begin
                            if (key_valid_q) begin
                                mode_d  = bus.iMode;
                                wkey_d  = key_q;
                                chunk_d = '0;
                                state_d = c_ENCRYPT;
                            end else begin
                                error_d = 1'b1;
                            end
                        end
                    end
                end

                c_ENCRYPT: begin
                    error_d = w_flag_rise;
                    msg_d   = msg_q << KEY_SIZE;
                    ct_d    = w_ct_next;
                    if (mode_q) begin
                        wkey_d = w_wkey_rot;
                    end
                    if (chunk_q == c_CHUNK_LAST) begin
                        chunk_d = '0;
                        bit_d   = '0;
                        state_d = c_SHIFT;
                    end else begin
                        chunk_d = chunk_q + c_CCNT_ONE;
                    end
                end

                c_SHIFT: begin
                    error_d     = w_flag_rise;
                    data_out_d  = ct_q[MSG_SIZE-1];
                    data_flag_d = 1'b1;
                    ct_d        = ct_q << 1;
                    // The last bit leaves while the FSM returns to IDLE; the
                    // flag drops on the following IDLE cycle.
                    if (bit_q == c_BIT_LAST) begin
                        bit_d   = '0;
                        state_d = c_IDLE;
                    end else begin
                        bit_d = bit_q + c_MCNT_ONE;
                    end
                end

                default: begin
                    state_d = c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_IDLE;
            key_q       <= '0;
            wkey_q      <= '0;
            key_cnt_q   <= '0;
            key_valid_q <= 1'b0;
            key_prev_q  <= 1'b0;
            msg_q       <= '0;
            msg_cnt_q   <= '0;
            msg_prev_q  <= 1'b0;
            mode_q      <= 1'b0;
            ct_q        <= '0;
            chunk_q     <= '0;
            bit_q       <= '0;
            data_out_q  <= 1'b0;
            data_flag_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            key_q       <= key_d;
            wkey_q      <= wkey_d;
            key_cnt_q   <= key_cnt_d;
            key_valid_q <= key_valid_d;
            key_prev_q  <= key_prev_d;
            msg_q       <= msg_d;
            msg_cnt_q   <= msg_cnt_d;
            msg_prev_q  <= msg_prev_d;
            mode_q      <= mode_d;
            ct_q        <= ct_d;
            chunk_q     <= chunk_d;
            bit_q       <= bit_d;
            data_out_q  <= data_out_d;
            data_flag_q <= data_flag_d;
            error_q     <= error_d;
        end
    end

    assign bus.oData_out  = data_out_q;
    assign bus.oData_flag = data_flag_q;
    assign bus.oBusy      = (state_q == c_ENCRYPT) || (state_q == c_SHIFT);
    assign bus.oKey_valid = key_valid_q;
    assign bus.oError     = error_q;

endmodule

`default_nettype wire

// File: tb/tb_xor_stream_engine.sv
// ============================================================================
//  Module      : tb_xor_stream_engine
//  Description : Randomised scoreboard bench for xor_stream_engine.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_xor_stream_engine;

    logic clk = 1'b0;
    logic rst = 1'b1;

    xor_stream_if bus_if ();

    xor_stream_engine #(
        .MSG_SIZE (64),
        .KEY_SIZE (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    int          n_vec      = 0;
    int          n_bad      = 0;
    int          mon_bits   = 0;
    int          total_bits = 0;
    int          err_pulses = 0;
    logic [63:0] acc        = '0;
    logic        ena_at_edge = 1'b0;
    logic [63:0] sb[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: split the message into bytes, XOR each with the current key,
    // rotating the key arithmetically between bytes in rolling mode.
    function automatic logic [63:0] model(input logic [7:0] key, input logic [63:0] msg, input bit mode);
        int          kv = int'(key);
        logic [63:0] ct = '0;
        for (int c = 0; c < 8; c++) begin
            int sh    = 56 - 8 * c;
            int chunk = int'((msg >> sh) & 64'hFF);
            ct = ct | (64'(chunk ^ kv) << sh);
            if (mode) kv = ((kv * 2) + (kv / 128)) % 256;
        end
        return ct;
    endfunction

    always @(posedge clk) ena_at_edge = bus_if.ena;

    // Monitor: reassembles each flagged stream and checks it against the scoreboard.
    always @(negedge clk) begin
        if (rst) begin
            mon_bits = 0;
            acc      = '0;
        end else if (ena_at_edge) begin
            if (bus_if.oError) err_pulses++;
            if (bus_if.oData_flag) begin
                acc = {acc[62:0], bus_if.oData_out};
                mon_bits++;
                total_bits++;
                if (mon_bits == 64) begin
                    chk("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) chk("ciphertext", acc, sb.pop_front());
                    mon_bits = 0;
                end
            end else if (mon_bits != 0) begin
                chk("stream_length", 64'(mon_bits), 64'd64);
                mon_bits = 0;
            end
        end
    end

    task automatic serial(input bit is_key, input logic [63:0] val, input int nbits, input bit mode);
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1;
            bus_if.iKey_flag = is_key;
            bus_if.iMsg_flag = !is_key;
            bus_if.iMode     = mode;
            bus_if.iData_in  = val[nbits-1-i];
        end
        @(posedge clk); #1;
        bus_if.iKey_flag = 1'b0;
        bus_if.iMsg_flag = 1'b0;
        bus_if.iData_in  = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while ((bus_if.oBusy || bus_if.oData_flag || sb.size() != 0) && c < 400) begin
            @(negedge clk);
            c++;
        end
        chk({name, "_done"}, 64'(c < 400), 64'd1);
    endtask

    task automatic wait_bits(input int target);
        int c = 0;
        while (mon_bits < target && c < 200) begin
            @(negedge clk);
            c++;
        end
        chk("wait_bits", 64'(c < 200), 64'd1);
    endtask

    task automatic run_msg(input logic [7:0] key, input logic [63:0] msg, input bit mode, input string name);
        sb.push_back(model(key, msg, mode));
        serial(1'b0, msg, 64, mode);
        wait_idle(name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          e0;
        int          b0;
        logic [7:0]  k;
        logic [63:0] m;
        bit          md;
        logic        held;

        bus_if.ena       = 1'b1;
        bus_if.iData_in  = 1'b0;
        bus_if.iKey_flag = 1'b0;
        bus_if.iMsg_flag = 1'b0;
        bus_if.iMode     = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_flag", 64'(bus_if.oData_flag), 64'd0);
        chk("rst_data_out",  64'(bus_if.oData_out),  64'd0);
        chk("rst_busy",      64'(bus_if.oBusy),      64'd0);
        chk("rst_key_valid", 64'(bus_if.oKey_valid), 64'd0);
        chk("rst_error",     64'(bus_if.oError),     64'd0);
        rst = 1'b0;

        // Static key with the reference vector, plus busy duration.
        serial(1'b1, 64'hAC, 8, 1'b0);
        chk("key_valid_after_load", 64'(bus_if.oKey_valid), 64'd1);
        sb.push_back(64'hAD8FE9CB25076143);
        serial(1'b0, 64'h0123456789ABCDEF, 64, 1'b0);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (bus_if.oBusy) n++;
            else if (n > 0) break;
        end
        chk("busy_cycles", 64'(n), 64'd72);
        wait_idle("static");

        // Rolling key, with first-bit latency.
        serial(1'b1, 64'h01, 8, 1'b0);
        sb.push_back(64'h0102040810204080);
        serial(1'b0, 64'h0, 64, 1'b1);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n++;
            if (bus_if.oData_flag) break;
        end
        chk("first_bit_latency", 64'(n), 64'd10);
        wait_idle("rolling");
        sb.push_back(64'h0101010101010101);
        serial(1'b0, 64'h0, 64, 1'b0);
        wait_idle("static_01");

        for (int r = 0; r < 4; r++) begin
            k  = 8'($urandom);
            m  = {$urandom, $urandom};
            md = 1'($urandom_range(0, 1));
            serial(1'b1, 64'(k), 8, 1'b0);
            run_msg(k, m, md, "random");
        end

        // Partial key then a full message: error, nothing streamed.
        rst = 1'b1; #3; rst = 1'b0;
        serial(1'b1, 64'h15, 5, 1'b0);
        chk("partial_key_valid", 64'(bus_if.oKey_valid), 64'd0);
        e0 = err_pulses;
        b0 = total_bits;
        serial(1'b0, {$urandom, $urandom}, 64, 1'b0);
        repeat (4) @(negedge clk);
        chk("nokey_error_pulses", 64'(err_pulses - e0), 64'd1);
        chk("nokey_no_stream",    64'(total_bits - b0), 64'd0);
        chk("nokey_busy",         64'(bus_if.oBusy),    64'd0);
        chk("nokey_key_valid",    64'(bus_if.oKey_valid), 64'd0);

        // Message flag raised during SHIFT.
        k = 8'h5A;
        serial(1'b1, 64'(k), 8, 1'b0);
        m = {$urandom, $urandom};
        sb.push_back(model(k, m, 1'b1));
        serial(1'b0, m, 64, 1'b1);
        wait_bits(3);
        e0 = err_pulses;
        @(posedge clk); #1;
        bus_if.iMsg_flag = 1'b1;
        bus_if.iData_in  = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        bus_if.iMsg_flag = 1'b0;
        bus_if.iData_in  = 1'b0;
        repeat (3) @(negedge clk);
        chk("busy_load_error", 64'(err_pulses - e0), 64'd1);
        chk("busy_load_key_valid", 64'(bus_if.oKey_valid), 64'd1);
        wait_idle("busy_load");
        run_msg(k, {$urandom, $urandom}, 1'b0, "held_key");

        // ena dropped mid-stream.
        b0 = total_bits;
        m  = {$urandom, $urandom};
        sb.push_back(model(k, m, 1'b1));
        serial(1'b0, m, 64, 1'b1);
        wait_bits(20);
        @(posedge clk); #1;
        bus_if.ena = 1'b0;
        held = bus_if.oData_out;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("ena_hold_flag", 64'(bus_if.oData_flag), 64'd1);
            chk("ena_hold_out",  64'(bus_if.oData_out),  64'(held));
        end
        bus_if.ena = 1'b1;
        wait_idle("ena_gate");
        chk("ena_gate_bits", 64'(total_bits - b0), 64'd64);

        // Asynchronous reset mid-SHIFT.
        m = {$urandom, $urandom};
        sb.push_back(model(k, m, 1'b0));
        serial(1'b0, m, 64, 1'b0);
        wait_bits(30);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("arst_data_flag", 64'(bus_if.oData_flag), 64'd0);
        chk("arst_data_out",  64'(bus_if.oData_out),  64'd0);
        chk("arst_busy",      64'(bus_if.oBusy),      64'd0);
        chk("arst_key_valid", 64'(bus_if.oKey_valid), 64'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        k = 8'hC3;
        serial(1'b1, 64'(k), 8, 1'b0);
        run_msg(k, {$urandom, $urandom}, 1'b1, "after_reset");

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
